branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Holds the program counter for the 16-bit MIPS datapath.
- Consumes the ID-stage branch comparator result (`is_equal`) and decides the next PC: sequential, branch-taken, or jump.
- Generates the one-cycle wrong-path flush for the ID stage.
- Keeps a saturating taken-redirect counter for performance debug.

Parameters:
- PC_W, 16, width of PC and all address ports.
- RESET_PC, 16'h0000, PC value loaded on reset.
- CNT_W, 16, width of the taken-redirect counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall; freezes PC and defers decisions.
- halt  in  1  halt instruction decoded in ID.
- is_branch  in  1  ID holds a BEQ.
- is_equal  in  1  comparator result for the ID operands.
- is_jump  in  1  ID holds an unconditional jump.
- id_pc  in  PC_W  PC of the instruction currently in ID.
- branch_off  in  PC_W  sign-extended word offset from ID.
- jump_target  in  PC_W  absolute jump word address.
- pc  out  PC_W  current fetch address (registered).
- pc_plus1  out  PC_W  pc+1, combinational from pc.
- flush  out  1  registered; the instruction in ID is wrong-path and must become a NOP.
- halted  out  1  registered; high in HALT.
- taken_count  out  CNT_W  number of redirects taken.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, flush=0, halted=0, taken_count=0, state=RUN.
  - Release is synchronous to the next rising edge.
- PC is word-addressed.
  - All adds are modulo 2^PC_W; wrap is not an error (FFFF+1=0000).
  - Branch target = id_pc + 1 + branch_off, two's-complement add, modulo 2^PC_W, no overflow flag.
- States: RUN, REDIRECT, HALT.
- RUN:
  - stall=1: pc holds, flush=0, no redirect, halt ignored. The same branch/jump is re-evaluated when stall drops.
  - stall=0, is_jump=1: pc<=jump_target; REDIRECT.
  - stall=0, is_branch=1, is_equal=1, is_jump=0: pc<=branch target; REDIRECT.
  - stall=0, halt=1, no redirect: pc holds; HALT.
  - Otherwise: pc<=pc+1.
  - Priority: jump > taken branch > halt > sequential.
  - Not-taken branch (is_equal=0) behaves as sequential.
- REDIRECT (exactly one cycle):
  - flush=1 during this cycle.
  - is_branch, is_jump and halt are ignored, because they are wrong-path.
  - If stall=0: pc<=pc+1 and return to RUN.
  - If stall=1: pc holds, stay in REDIRECT with flush remaining 1 until stall=0. The wrong-path instruction stays squashed.
- HALT:
  - pc frozen, halted=1, flush=0.
  - All inputs ignored; exit only by rst.
- taken_count:
  - Increments on each transition into REDIRECT.
  - Saturates at all-ones; no wrap.
- flush is 0 in every state except REDIRECT.
- Back-to-back case: a taken branch that is the first instruction at the target (ID in the cycle after REDIRECT) is honoured normally.
- Reset mid-REDIRECT or mid-HALT: immediately forces RESET_PC, state RUN, outputs cleared.

Test Plan:
- Reset with rst=1 for 2 cycles, then release and run 4 cycles with no controls -> pc 0000,0001,0002,0003; flush=0; taken_count=0.
- Taken branch: id_pc=0004, branch_off=0005, is_branch=1, is_equal=1 -> next pc=000A; flush=1 for exactly one cycle; then pc=000B; taken_count=1.
- Not-taken and negative offset: is_equal=0 -> pc increments, no flush. Then id_pc=0010, branch_off=FFFC, taken -> pc=000D.
- Jump/branch priority and wrap: is_jump=1 with jump_target=FFFF together with a taken branch -> pc=FFFF; next pc=0000.
  - Wrong-path is_jump asserted during REDIRECT is ignored.
- Stall: taken branch with stall=1 for 3 cycles -> pc unchanged, flush=0. Stall drops -> redirect.
  - Stall during REDIRECT -> flush held at 1 and pc frozen.
- Halt then reset: halt=1 at pc=0020 -> pc stays 0020 and halted=1 for 10 cycles. Async rst mid-cycle -> pc=0000 and halted=0 before the next edge.
- Saturation: preload by running 65535 redirects -> taken_count=FFFF, and it stays FFFF after the next taken branch.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Program counter and next-PC selection for the 16-bit MIPS datapath.
// Resolves ID-stage branches and jumps, squashes the wrong-path ID slot, and counts redirects.
module branch_pc_unit #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             halt_i,
  input  logic             is_branch_i,
  input  logic             is_equal_i,
  input  logic             is_jump_i,
  input  logic [PC_W-1:0]  id_pc_i,
  input  logic [PC_W-1:0]  branch_off_i,
  input  logic [PC_W-1:0]  jump_target_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  pc_plus1_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] taken_count_o
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_REDIRECT = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             halted_q, halted_d;
  logic [PC_W-1:0]  pc_plus1;
  logic [PC_W-1:0]  branch_tgt;

  assign pc_plus1   = pc_q + PC_W'(1);
  assign branch_tgt = id_pc_i + PC_W'(1) + branch_off_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (!stall_i) begin
          if (is_jump_i) begin
            pc_d    = jump_target_i;
            state_d = S_REDIRECT;
          end else if (is_branch_i && is_equal_i) begin
            pc_d    = branch_tgt;
            state_d = S_REDIRECT;
          end else if (halt_i) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_plus1;
          end
        end
      end
      // Control inputs here belong to the squashed instruction, so only stall matters.
      S_REDIRECT: begin
        if (!stall_i) begin
          pc_d    = pc_plus1;
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    if ((state_q == S_RUN) && (state_d == S_REDIRECT) && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    flush_d  = (state_d == S_REDIRECT);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_plus1_o    = pc_plus1;
  assign flush_o       = flush_q;
  assign halted_o      = halted_q;
  assign taken_count_o = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit; a second narrow-counter instance covers saturation.
module tb_branch_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt;
  logic        is_branch;
  logic        is_equal;
  logic        is_jump;
  logic [15:0] id_pc;
  logic [15:0] branch_off;
  logic [15:0] jump_target;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        flush;
  logic        halted;
  logic [15:0] taken_count;

  logic        s_jump;
  logic [15:0] s_pc;
  logic [15:0] s_pc_plus1;
  logic        s_flush;
  logic        s_halted;
  logic [3:0]  s_count;

  int n_checks = 0;
  int n_pass   = 0;

  branch_pc_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .halt_i        (halt),
    .is_branch_i   (is_branch),
    .is_equal_i    (is_equal),
    .is_jump_i     (is_jump),
    .id_pc_i       (id_pc),
    .branch_off_i  (branch_off),
    .jump_target_i (jump_target),
    .pc_o          (pc),
    .pc_plus1_o    (pc_plus1),
    .flush_o       (flush),
    .halted_o      (halted),
    .taken_count_o (taken_count)
  );

  branch_pc_unit #(.PC_W(16), .RESET_PC(16'h0000), .CNT_W(4)) dut_sat (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (1'b0),
    .halt_i        (1'b0),
    .is_branch_i   (1'b0),
    .is_equal_i    (1'b0),
    .is_jump_i     (s_jump),
    .id_pc_i       (16'h0000),
    .branch_off_i  (16'h0000),
    .jump_target_i (16'h0100),
    .pc_o          (s_pc),
    .pc_plus1_o    (s_pc_plus1),
    .flush_o       (s_flush),
    .halted_o      (s_halted),
    .taken_count_o (s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall = 0; halt = 0; is_branch = 0; is_equal = 0; is_jump = 0;
    id_pc = '0; branch_off = '0; jump_target = '0;
  endtask

  initial begin
    clear_ctrl();
    s_jump = 0;
    rst = 1;
    step(); step();
    check("rst_pc", pc, 16'h0000);
    check("rst_flush", flush, 0);
    check("rst_halted", halted, 0);
    check("rst_count", taken_count, 0);
    rst = 0;

    check("seq_pc0", pc, 16'h0000);
    check("pc_plus1", pc_plus1, 16'h0001);
    step(); check("seq_pc1", pc, 16'h0001);
    step(); check("seq_pc2", pc, 16'h0002);
    step(); check("seq_pc3", pc, 16'h0003);
    check("seq_flush", flush, 0);

    // taken branch: 4 + 1 + 5
    id_pc = 16'h0004; branch_off = 16'h0005; is_branch = 1; is_equal = 1;
    step();
    check("br_pc", pc, 16'h000A);
    check("br_flush", flush, 1);
    check("br_count", taken_count, 1);
    clear_ctrl();
    step();
    check("br_after_pc", pc, 16'h000B);
    check("br_after_flush", flush, 0);

    is_branch = 1; is_equal = 0;
    step();
    check("nt_pc", pc, 16'h000C);
    check("nt_flush", flush, 0);

    // negative offset: 0x10 + 1 - 4
    id_pc = 16'h0010; branch_off = 16'hFFFC; is_equal = 1;
    step();
    check("neg_pc", pc, 16'h000D);
    check("neg_flush", flush, 1);
    check("neg_count", taken_count, 2);
    clear_ctrl();
    is_jump = 1; jump_target = 16'h1234; is_branch = 1; is_equal = 1; halt = 1;
    step();
    check("wp_pc", pc, 16'h000E);
    check("wp_flush", flush, 0);
    check("wp_count", taken_count, 2);
    clear_ctrl();

    is_jump = 1; jump_target = 16'hFFFF; is_branch = 1; is_equal = 1;
    id_pc = 16'h0004; branch_off = 16'h0005;
    step();
    check("prio_pc", pc, 16'hFFFF);
    check("prio_plus1", pc_plus1, 16'h0000);
    check("prio_count", taken_count, 3);
    clear_ctrl();
    step();
    check("wrap_pc", pc, 16'h0000);
    check("wrap_flush", flush, 0);
    step();
    check("wrap_pc1", pc, 16'h0001);

    // stall defers a taken branch to 0x30 + 1 + 2
    id_pc = 16'h0030; branch_off = 16'h0002; is_branch = 1; is_equal = 1; stall = 1; halt = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 16'h0001);
      check("stall_flush", flush, 0);
      check("stall_halted", halted, 0);
    end
    stall = 0; halt = 0;
    step();
    check("unstall_pc", pc, 16'h0033);
    check("unstall_flush", flush, 1);
    check("unstall_count", taken_count, 4);
    clear_ctrl();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rstall_pc", pc, 16'h0033);
      check("rstall_flush", flush, 1);
    end
    stall = 0;
    step();
    check("rstall_exit_pc", pc, 16'h0034);
    check("rstall_exit_flush", flush, 0);
    check("rstall_count", taken_count, 4);

    // back-to-back: taken branch in the first slot after REDIRECT
    is_jump = 1; jump_target = 16'h0050;
    step();
    check("b2b_j_pc", pc, 16'h0050);
    clear_ctrl();
    step();
    check("b2b_seq_pc", pc, 16'h0051);
    id_pc = 16'h0050; branch_off = 16'h0010; is_branch = 1; is_equal = 1;
    step();
    check("b2b_br_pc", pc, 16'h0061);
    check("b2b_br_flush", flush, 1);
    check("b2b_count", taken_count, 6);
    clear_ctrl();
    step();

    is_jump = 1; jump_target = 16'h001F;
    step();
    clear_ctrl();
    step();
    check("pre_halt_pc", pc, 16'h0020);
    halt = 1;
    step();
    is_jump = 1; jump_target = 16'h7777; is_branch = 1; is_equal = 1;
    for (int i = 0; i < 10; i++) begin
      check("halt_pc", pc, 16'h0020);
      check("halt_halted", halted, 1);
      check("halt_flush", flush, 0);
      step();
    end
    check("halt_count", taken_count, 7);
    #2 rst = 1;
    #1;
    check("async_pc", pc, 16'h0000);
    check("async_halted", halted, 0);
    check("async_count", taken_count, 0);
    clear_ctrl();
    step();
    rst = 0;
    step();
    check("post_rst_pc", pc, 16'h0001);

    is_jump = 1; jump_target = 16'h0040;
    step();
    check("mid_redir_flush", flush, 1);
    clear_ctrl();
    #2 rst = 1;
    #1;
    check("mid_redir_rst_flush", flush, 0);
    check("mid_redir_rst_pc", pc, 16'h0000);
    step();
    rst = 0;

    // saturation on the 4-bit counter instance: a redirect every other cycle
    s_jump = 1;
    for (int i = 1; i <= 31; i++) begin
      step();
      if (i == 27) check("sat_count_e", s_count, 4'hE);
      if (i == 29) begin
        check("sat_count_f", s_count, 4'hF);
        check("sat_flush", s_flush, 1);
      end
    end
    check("sat_hold_flush", s_flush, 1);
    check("sat_hold", s_count, 4'hF);
    s_jump = 0;
    check("sat_main_idle", taken_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
